// File: rtl/fp_normalize_round_if.sv
// Handshake and data bundle between the FP add/align datapath, the
// normalise/round stage and the result consumer.
interface fp_normalize_round_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [7:0]  in_exponent;
   logic [26:0] in_mant;
   logic        in_sticky;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_overflow;
   logic        out_underflow;
   logic        out_inexact;

   modport master (
      output in_valid, in_sign, in_exponent, in_mant, in_sticky, out_ready,
      input  in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
   );

   modport slave (
      input  in_valid, in_sign, in_exponent, in_mant, in_sticky, out_ready,
      output in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
   );
endinterface

// File: rtl/fp_normalize_round.sv
// Post-add normalise / round-to-nearest-even / pack stage of the single
// precision FP adder, with a multi-cycle left-shift normalisation loop.
module fp_normalize_round #(
   parameter int LZ_STEP = 1
) (
   input logic                 clk,
   input logic                 reset,
   fp_normalize_round_if.slave bus
);

   typedef enum logic [2:0] {IDLE, PRE, SHIFT, ROUND, DONE} state_t;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exponent;
      logic [22:0] significand;
   } fp_t;

   state_t      state;
   logic        sign_q;
   logic [7:0]  exp_q;
   logic [26:0] mant_q;
   logic        sticky_q;
   logic        valid_q;
   fp_t         result_q;
   logic        overflow_q;
   logic        underflow_q;
   logic        inexact_q;

   logic [4:0]  lz;
   logic [7:0]  step;
   logic [26:0] shift_mant;
   logic [7:0]  shift_exp;

   logic        rnd_g;
   logic        rnd_s;
   logic        rnd_up;
   logic [24:0] rnd_sum;
   logic [23:0] rnd_sig;
   logic [8:0]  rnd_exp;
   logic        rnd_hidden;
   logic        rnd_inexact;
   logic        rnd_ovf;
   fp_t         rnd_word;

   assign bus.in_ready      = (state == IDLE);
   assign bus.out_valid     = valid_q;
   assign bus.out_result    = result_q;
   assign bus.out_overflow  = overflow_q;
   assign bus.out_underflow = underflow_q;
   assign bus.out_inexact   = inexact_q;

   // One normalisation step: limited by LZ_STEP, the remaining leading zeros
   // and the distance to the minimum normal exponent.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      lz = 5'd26;
      for (int i = 0; i < 26; i++) begin
         if (mant_q[i]) lz = 5'(25 - i);
      end
      step = 8'(LZ_STEP);
      if ({3'b000, lz} < step) step = {3'b000, lz};
      if ((exp_q - 8'd1) < step) step = exp_q - 8'd1;
      shift_mant = mant_q << step;
      shift_exp  = exp_q - step;
   end

   always_comb begin
      rnd_g       = mant_q[1];
      rnd_s       = mant_q[0] | sticky_q;
      rnd_up      = rnd_g & (rnd_s | mant_q[2]);
      rnd_sum     = {1'b0, mant_q[25:2]} + {24'd0, rnd_up};
      rnd_sig     = rnd_sum[23:0];
      rnd_exp     = {1'b0, exp_q};
      if (rnd_sum[24]) begin
         rnd_sig = rnd_sum[24:1];
         rnd_exp = {1'b0, exp_q} + 9'd1;
      end else if (!mant_q[25] && rnd_sum[23]) begin
         // Subnormal rounded up into the smallest normal.
         rnd_exp = 9'd1;
      end
      rnd_hidden  = rnd_sig[23];
      rnd_inexact = rnd_g | rnd_s;
      rnd_ovf     = rnd_hidden && (rnd_exp >= 9'h0FF);
      if (rnd_ovf) begin
         rnd_word = {sign_q, 8'hFF, 23'd0};
      end else begin
         rnd_word = {sign_q, (rnd_hidden ? rnd_exp[7:0] : 8'd0), rnd_sig[22:0]};
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: all sequential state uses non-blocking assignments.
      if (reset) begin
         state       <= IDLE;
         sign_q      <= 1'b0;
         exp_q       <= '0;
         mant_q      <= '0;
         sticky_q    <= 1'b0;
         valid_q     <= 1'b0;
         result_q    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         inexact_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  sign_q   <= bus.in_sign;
                  exp_q    <= bus.in_exponent;
                  mant_q   <= bus.in_mant;
                  sticky_q <= bus.in_sticky;
                  state    <= PRE;
               end
            end
            PRE: begin
               if (exp_q == 8'hFF) begin
                  result_q    <= {sign_q, 8'hFF, mant_q[24:2]};
                  overflow_q  <= 1'b0;
                  underflow_q <= 1'b0;
                  inexact_q   <= 1'b0;
                  valid_q     <= 1'b1;
                  state       <= DONE;
               end else if (mant_q == '0) begin
                  result_q    <= '0;
                  overflow_q  <= 1'b0;
                  underflow_q <= 1'b0;
                  inexact_q   <= 1'b0;
                  valid_q     <= 1'b1;
                  state       <= DONE;
               end else if (mant_q[26]) begin
                  mant_q   <= mant_q >> 1;
                  sticky_q <= sticky_q | mant_q[0];
                  exp_q    <= exp_q + 8'd1;
                  state    <= ROUND;
               end else if (mant_q[25] || exp_q == 8'd0) begin
                  state <= ROUND;
               end else begin
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               mant_q <= shift_mant;
               exp_q  <= shift_exp;
               if (shift_mant[25] || shift_exp == 8'd1) state <= ROUND;
            end
            ROUND: begin
               result_q    <= rnd_word;
               overflow_q  <= rnd_ovf;
               underflow_q <= !rnd_hidden && rnd_inexact;
               inexact_q   <= rnd_inexact;
               valid_q     <= 1'b1;
               state       <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  valid_q <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_normalize_round.sv
// Self-checking bench: two instances (LZ_STEP 1 and 8) driven in lockstep and
// compared against an arithmetic model of normalise / round-to-nearest-even.
module tb_fp_normalize_round;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_sign;
   logic [7:0]  in_exponent;
   logic [26:0] in_mant;
   logic        in_sticky;
   logic        out_ready;
   int          n_checks = 0;
   int          n_pass   = 0;

   always #5 clk = ~clk;

   fp_normalize_round_if bus1 ();
   fp_normalize_round_if bus8 ();

   assign bus1.in_valid    = in_valid;
   assign bus1.in_sign     = in_sign;
   assign bus1.in_exponent = in_exponent;
   assign bus1.in_mant     = in_mant;
   assign bus1.in_sticky   = in_sticky;
   assign bus1.out_ready   = out_ready;
   assign bus8.in_valid    = in_valid;
   assign bus8.in_sign     = in_sign;
   assign bus8.in_exponent = in_exponent;
   assign bus8.in_mant     = in_mant;
   assign bus8.in_sticky   = in_sticky;
   assign bus8.out_ready   = out_ready;

   fp_normalize_round #(.LZ_STEP(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
   fp_normalize_round #(.LZ_STEP(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h, want %h", tag, got, want);
   endtask

   // Value-level model: significand as an integer, rounding by comparing the
   // discarded remainder against half an ulp.
   function automatic void model(input logic s, input logic [7:0] e_in, input logic [26:0] m_in,
                                 input logic st_in, input int lz_step,
                                 output logic [31:0] res, output logic [2:0] flg, output int lat);
      longint m;
      longint keep;
      int     e;
      int     low;
      int     shifted;
      bit     up;
      bit     hidden;
      bit     inexact;
      bit     ovf;
      flg = 3'b000;
      if (e_in == 8'hFF) begin
         res = {s, 8'hFF, m_in[24:2]};
         lat = 2;
         return;
      end
      if (m_in == 27'd0) begin
         res = 32'd0;
         lat = 2;
         return;
      end
      m   = longint'(m_in);
      e   = int'(e_in);
      low = int'(st_in);
      lat = 3;
      if (m >= (64'd1 << 26)) begin
         if (m % 2 != 0) low = 1;
         m = m / 2;
         e = e + 1;
      end else if (m < (64'd1 << 25) && e != 0) begin
         shifted = 0;
         while (m < (64'd1 << 25) && e > 1) begin
            m = m * 2;
            e = e - 1;
            shifted++;
         end
         lat = 3 + ((shifted == 0) ? 1 : (shifted + lz_step - 1) / lz_step);
      end
      keep    = m / 4;
      low     = int'(m % 4) * 2 + low;
      up      = (low > 4) || (low == 4 && keep % 2 == 1);
      inexact = (low != 0);
      keep    = keep + longint'(up);
      if (keep >= (64'd1 << 24)) begin
         keep = keep / 2;
         e    = e + 1;
      end
      hidden = (keep >= (64'd1 << 23));
      if (hidden && e == 0) e = 1;
      ovf = hidden && e >= 255;
      if (ovf) res = {s, 8'hFF, 23'd0};
      else     res = {s, (hidden ? 8'(e) : 8'd0), 23'(keep)};
      flg = {ovf, !hidden && inexact, inexact};
   endfunction

   task automatic run_op(input logic s, input logic [7:0] e, input logic [26:0] m,
                         input logic st, input int hold);
      logic [31:0] want1, want8;
      logic [2:0]  flg1, flg8;
      int          lat_want1, lat_want8;
      int          lat1, lat8;
      model(s, e, m, st, 1, want1, flg1, lat_want1);
      model(s, e, m, st, 8, want8, flg8, lat_want8);
      lat1 = 0;
      lat8 = 0;
      in_sign     = s;
      in_exponent = e;
      in_mant     = m;
      in_sticky   = st;
      in_valid    = 1'b1;
      out_ready   = 1'b0;
      check("idle in_ready", {30'd0, bus8.in_ready, bus1.in_ready}, 32'd3);
      for (int cyc = 1; cyc <= 100 && (lat1 == 0 || lat8 == 0); cyc++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         if (lat1 == 0 && bus1.out_valid) lat1 = cyc;
         if (lat8 == 0 && bus8.out_valid) lat8 = cyc;
      end
      repeat (hold) begin
         @(posedge clk);
         #1;
         check("hold result1", bus1.out_result, want1);
         check("hold in_ready", {30'd0, bus8.in_ready, bus1.in_ready}, 32'd0);
      end
      check("result1", bus1.out_result, want1);
      check("result8", bus8.out_result, want8);
      check("flags1", {29'd0, bus1.out_overflow, bus1.out_underflow, bus1.out_inexact}, {29'd0, flg1});
      check("flags8", {29'd0, bus8.out_overflow, bus8.out_underflow, bus8.out_inexact}, {29'd0, flg8});
      check("latency1", lat1, lat_want1);
      check("latency8", lat8, lat_want8);
      check("done in_ready", {30'd0, bus8.in_ready, bus1.in_ready}, 32'd0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("post out_valid", {30'd0, bus8.out_valid, bus1.out_valid}, 32'd0);
      check("post in_ready", {30'd0, bus8.in_ready, bus1.in_ready}, 32'd3);
   endtask

   logic [26:0] rm;
   logic [7:0]  re;

   initial begin
      reset       = 1'b1;
      in_valid    = 1'b0;
      in_sign     = 1'b0;
      in_exponent = 8'd0;
      in_mant     = 27'd0;
      in_sticky   = 1'b0;
      out_ready   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset out_valid", {30'd0, bus8.out_valid, bus1.out_valid}, 32'd0);
      check("reset result1", bus1.out_result, 32'd0);
      check("reset result8", bus8.out_result, 32'd0);
      check("reset flags", {26'd0, bus8.out_overflow, bus8.out_underflow, bus8.out_inexact,
                            bus1.out_overflow, bus1.out_underflow, bus1.out_inexact}, 32'd0);
      check("reset in_ready", {30'd0, bus8.in_ready, bus1.in_ready}, 32'd3);
      reset = 1'b0;

      run_op(1'b0, 8'd127, 27'h4000000, 1'b0, 0);   // 1.0 + 1.0
      run_op(1'b0, 8'd127, 27'h0000004, 1'b0, 0);   // deep cancellation
      run_op(1'b0, 8'd127, 27'h2000002, 1'b0, 0);   // tie, even stays
      run_op(1'b0, 8'd127, 27'h2000006, 1'b0, 0);   // tie, odd rounds up
      run_op(1'b0, 8'd127, 27'h2000002, 1'b1, 0);   // above half
      run_op(1'b0, 8'd254, 27'h3FFFFFF, 1'b0, 0);   // overflow
      run_op(1'b0, 8'd10,  27'h0000004, 1'b0, 0);   // exact subnormal
      run_op(1'b1, 8'd127, 27'h0000000, 1'b0, 0);   // zero
      run_op(1'b1, 8'hFF,  27'h0400000, 1'b0, 0);   // NaN pass-through
      run_op(1'b0, 8'd1,   27'h1FFFFFE, 1'b0, 0);   // subnormal rounds to min normal
      run_op(1'b0, 8'd0,   27'h0000003, 1'b1, 0);   // tiny and inexact
      run_op(1'b0, 8'd100, 27'h2345678, 1'b0, 5);   // backpressure

      // Reset in the middle of normalisation.
      in_sign     = 1'b0;
      in_exponent = 8'd127;
      in_mant     = 27'h0000004;
      in_sticky   = 1'b0;
      in_valid    = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("abort out_valid", {30'd0, bus8.out_valid, bus1.out_valid}, 32'd0);
      check("abort in_ready", {30'd0, bus8.in_ready, bus1.in_ready}, 32'd3);

      // Reset together with in_valid: nothing may be accepted.
      in_mant  = 27'h4000000;
      in_valid = 1'b1;
      reset    = 1'b1;
      @(posedge clk);
      #1;
      reset    = 1'b0;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("reset-win out_valid", {30'd0, bus8.out_valid, bus1.out_valid}, 32'd0);
      check("reset-win in_ready", {30'd0, bus8.in_ready, bus1.in_ready}, 32'd3);

      for (int n = 0; n < 150; n++) begin
         re = 8'($urandom_range(1, 254));
         case ($urandom_range(0, 9))
            0:       rm = {1'b1, 26'($urandom)};
            1, 2, 3: rm = {2'b01, 25'($urandom)};
            4, 5, 6: rm = {1'b0, 26'($urandom)} >> $urandom_range(2, 26);
            7: begin
               re = 8'($urandom_range(0, 12));
               rm = {1'b0, 26'($urandom)} >> $urandom_range(2, 26);
            end
            8: begin
               re = 8'($urandom_range(250, 254));
               rm = {2'b01, 25'h1FFFFFF ^ 25'($urandom_range(0, 7))};
            end
            default: begin
               rm = $urandom_range(0, 1) ? 27'd0 : 27'($urandom);
               if (rm != 27'd0) re = 8'hFF;
            end
         endcase
         run_op(1'($urandom), re, rm, 1'($urandom), $urandom_range(0, 1));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fp_normalize_round.md
Name: fp_normalize_round

Overview:
- Post-add stage of the single-precision FP adder. Consumes the raw significand sum, carry, guard/round/sticky bits and the pre-normalisation exponent from the add/align datapath.
- Normalises the sum with a multi-cycle left-shift loop, or a single right shift on carry-out, then rounds to nearest-even.
- Packs the IEEE-754 result word (fp_t layout: sign, exponent[7:0], significand[22:0]) and raises flags.
- Uses a valid/ready handshake on both sides.

Parameters:
- LZ_STEP, 1, maximum left-shift bits per SHIFT cycle. Legal values: 1, 2, 4, 8.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept; equals (state==IDLE)
- in_sign  in  1  sign of sum
- in_exponent  in  8  biased exponent of larger operand
- in_mant  in  27  [26] carry-out, [25] hidden, [24:2] fraction, [1] guard, [0] round
- in_sticky  in  1  OR of bits shifted out during alignment
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_result  out  32  packed fp_t {sign, exponent, significand}
- out_overflow  out  1  result rounded to infinity
- out_underflow  out  1  result tiny and inexact
- out_inexact  out  1  any of G/R/S nonzero at rounding

Behaviour:
- Reset (synchronous, highest priority, may abort any state):
  - state=IDLE, out_valid=0, out_result=0, all flags 0, internal registers 0.
  - In-flight operation is discarded.
- States: IDLE, PRE, SHIFT, ROUND, DONE.
- IDLE:
  - in_ready=1. On in_valid&&in_ready, latch inputs and go to PRE.
- PRE (one cycle):
  - in_exponent==8'hFF: pass-through. Result = {sign, 8'hFF, mant[24:2]}, no flags. Go to DONE directly.
  - mant==0: result +0 (sign forced 0), no flags. Go to DONE.
  - mant[26]=1: shift right 1; the new sticky absorbs the old bit0; exponent+1. Go to ROUND.
  - Else, mant[25]=1 or exponent==0 (subnormal input): go to ROUND.
  - Otherwise: go to SHIFT.
- SHIFT, each cycle:
  - Shift left by n = min(LZ_STEP, leading zeros above bit25, exponent-1). Exponent -= n. Zeros enter at bit0; sticky is unchanged.
  - Exit to ROUND when mant[25]=1 or exponent==1.
  - Cycle count = ceil(shift/LZ_STEP).
- ROUND:
  - Rounding: S' = round|sticky; up = guard & (S' | fraction LSB); fraction += up.
  - Fraction carry into the hidden position: if the hidden bit was already 1, shift right and exponent+1. If the hidden bit was 0 (subnormal), the result becomes normal with exponent 1.
  - Exponent encoding: exponent field = 0 if the final hidden bit is 0, else the exponent.
  - Overflow: exponent reaching 8'hFF gives ±infinity {sign, 8'hFF, 0} with out_overflow=1.
  - Flags: out_inexact = guard|S'; out_underflow = (final hidden bit 0) & inexact.
  - Register the result and flags, then go to DONE.
- DONE:
  - out_valid=1. out_result and flags are held stable until out_ready=1.
  - On the handshake cycle go to IDLE; out_valid drops next cycle.
  - in_ready=0 throughout DONE; there is no same-cycle accept.
- Latency (acceptance edge to first cycle with out_valid=1):
  - 3 cycles with no left shift.
  - 3 + ceil(lz/LZ_STEP) cycles with a left shift.
  - 2 cycles for zero, NaN or infinity.
- Throughput: one result per (latency + 1) cycles minimum.
- Simultaneous reset and in_valid: reset wins, input is not accepted.

Test Plan:
- 1.0+1.0 (in_mant=27'h4000000, exp 127, sign 0): out_result=32'h40000000, flags 0, out_valid 3 cycles after accept.
- Cancellation (in_mant=27'h0000004, exp 127, LZ_STEP=1): out_result=32'h34000000 after 26 cycles. Repeat with LZ_STEP=8: 3+3=6 cycles, same result.
- RNE ties:
  - in_mant=27'h2000002, exp 127: 32'h3F800000, inexact=1.
  - in_mant=27'h2000006: 32'h3F800002, inexact=1.
  - in_mant=27'h2000002 with sticky=1: 32'h3F800001.
- Overflow (in_mant=27'h3FFFFFF, exp 254): out_result=32'h7F800000, out_overflow=1, out_inexact=1.
- Underflow and zero:
  - in_mant=27'h0000004, exp 10: 32'h00000200, out_underflow=0.
  - in_mant=0, sign 1: 32'h00000000.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE: out_result stable, in_ready=0.
  - Assert reset during SHIFT: next cycle state IDLE, out_valid=0, in_ready=1 after reset drops.
